// File: rtl/icache_axi_refill_pkg.sv
// Shared state encodings, AXI constants and helpers for the icache refill engine.
package icache_axi_refill_pkg;

    typedef enum logic [1:0] {
        ICACHE_REFILL_IDLE = 2'd0,
        ICACHE_REFILL_AR   = 2'd1,
        ICACHE_REFILL_R    = 2'd2,
        ICACHE_REFILL_DONE = 2'd3
    } refill_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam int unsigned ICACHE_LINE_BUS_W = 256;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp != AXI_RESP_OKAY);
    endfunction

endpackage

// File: rtl/icache_line_buf.sv
// Line assembly buffer: one 32-bit word written per beat, whole line exposed flat.
module icache_line_buf #(
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned IDX_W      = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we_i,
    input  logic [IDX_W-1:0]          idx_i,
    input  logic [31:0]               data_i,
    output logic [32*LINE_WORDS-1:0]  line_o
);

    logic [31:0] words_r [LINE_WORDS];

    // Word storage, cleared on reset and written one beat at a time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(LINE_WORDS); k++) begin
                words_r[k] <= 32'd0;
            end
        end else if (we_i) begin
            words_r[idx_i] <= data_i;
        end
    end

    // Flatten the array so word k lands at bits [32k+31:32k].
    always_comb begin
        line_o = '0;
        for (int k = 0; k < int'(LINE_WORDS); k++) begin
            line_o[32*k +: 32] = words_r[k];
        end
    end

endmodule

// File: rtl/icache_axi_refill.sv
// Icache line refill engine: one AXI4 read burst per miss, assembled into a full line.
// Optional ICACHE_CWF_EN selects a critical-word-first WRAP burst.
module icache_axi_refill
    import icache_axi_refill_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 8,
    parameter logic [3:0]  AXI_ID     = 4'd0,
    parameter int unsigned OFFSET_W   = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_i,
    input  logic [31:0]               addr_i,
    output logic                      rend_o,
    output logic [32*LINE_WORDS-1:0]  line_o,
    output logic                      busy_o,
    output logic                      err_o,
    output logic [3:0]                arid_o,
    output logic [31:0]               araddr_o,
    output logic [7:0]                arlen_o,
    output logic [2:0]                arsize_o,
    output logic [1:0]                arburst_o,
    output logic                      arvalid_o,
    input  logic                      arready_i,
    input  logic [3:0]                rid_i,
    input  logic [31:0]               rdata_i,
    input  logic [1:0]                rresp_i,
    input  logic                      rlast_i,
    input  logic                      rvalid_i,
    output logic                      rready_o
);

    localparam int unsigned      IDX_W     = $clog2(LINE_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LINE_WORDS - 1);
    localparam logic [31:0]      LINE_MASK = ~((32'd1 << OFFSET_W) - 32'd1);

    refill_state_e    state_r;
    logic [IDX_W-1:0] cnt_r;
    logic [IDX_W-1:0] base_idx_r;
    logic             err_flag_r;
    logic             armed_r;
    logic             arvalid_r;
    logic             rready_r;
    logic             rend_r;
    logic             err_r;
    logic [31:0]      araddr_r;

    logic             beat_s;
    logic             last_beat_s;
    logic             beat_err_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic [31:0]      start_addr_s;
    logic [IDX_W-1:0] start_idx_s;
    logic             unused_s;

    assign arid_o    = AXI_ID;
    assign arlen_o   = 8'(LINE_WORDS - 1);
    assign arsize_o  = 3'b010;
    assign busy_o    = (state_r != ICACHE_REFILL_IDLE);
    assign arvalid_o = arvalid_r;
    assign rready_o  = rready_r;
    assign rend_o    = rend_r;
    assign err_o     = err_r;
    assign araddr_o  = araddr_r;

`ifdef ICACHE_CWF_EN
    assign arburst_o    = AXI_BURST_WRAP;
    assign start_addr_s = {addr_i[31:2], 2'b00};
    assign start_idx_s  = addr_i[OFFSET_W-1:2];
    assign unused_s     = ^{rid_i, addr_i[1:0]};
`else
    assign arburst_o    = AXI_BURST_INCR;
    assign start_addr_s = addr_i & LINE_MASK;
    assign start_idx_s  = {IDX_W{1'b0}};
    assign unused_s     = ^{rid_i, addr_i[OFFSET_W-1:0]};
`endif

    assign beat_s      = (state_r == ICACHE_REFILL_R) && rvalid_i;
    assign last_beat_s = (cnt_r == LAST_IDX);
    assign wr_idx_s    = base_idx_r + cnt_r;
    // Completion is by beat count; a misplaced or missing RLAST only flags an error.
    assign beat_err_s  = resp_is_err(rresp_i) | (rlast_i != last_beat_s);

    // Refill FSM with registered AXI handshakes, completion pulse and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ICACHE_REFILL_IDLE;
            cnt_r      <= {IDX_W{1'b0}};
            base_idx_r <= {IDX_W{1'b0}};
            err_flag_r <= 1'b0;
            armed_r    <= 1'b1;
            arvalid_r  <= 1'b0;
            rready_r   <= 1'b0;
            rend_r     <= 1'b0;
            err_r      <= 1'b0;
            araddr_r   <= 32'd0;
        end else begin
            case (state_r)
                ICACHE_REFILL_IDLE: begin
                    rend_r <= 1'b0;
                    err_r  <= 1'b0;
                    // A request still held from the previous miss must drop before re-arming.
                    if (req_i && armed_r) begin
                        araddr_r   <= start_addr_s;
                        base_idx_r <= start_idx_s;
                        err_flag_r <= 1'b0;
                        cnt_r      <= {IDX_W{1'b0}};
                        arvalid_r  <= 1'b1;
                        state_r    <= ICACHE_REFILL_AR;
                    end else if (!req_i) begin
                        armed_r <= 1'b1;
                    end
                end
                ICACHE_REFILL_AR: begin
                    if (arready_i) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= ICACHE_REFILL_R;
                    end
                end
                ICACHE_REFILL_R: begin
                    if (beat_s) begin
                        cnt_r <= cnt_r + IDX_W'(1);
                        if (beat_err_s) begin
                            err_flag_r <= 1'b1;
                        end
                        if (last_beat_s) begin
                            rready_r <= 1'b0;
                            rend_r   <= 1'b1;
                            err_r    <= err_flag_r | beat_err_s;
                            state_r  <= ICACHE_REFILL_DONE;
                        end
                    end
                end
                ICACHE_REFILL_DONE: begin
                    rend_r  <= 1'b0;
                    err_r   <= 1'b0;
                    armed_r <= 1'b0;
                    state_r <= ICACHE_REFILL_IDLE;
                end
                default: begin
                    state_r <= ICACHE_REFILL_IDLE;
                end
            endcase
        end
    end

    icache_line_buf #(
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (IDX_W)
    ) u_line_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (beat_s),
        .idx_i  (wr_idx_s),
        .data_i (rdata_i),
        .line_o (line_o)
    );

endmodule

// File: doc/icache_axi_refill.md
Name: icache_axi_refill

Overview:
- Refill engine directly downstream of the icache second stage.
- Accepts a line-miss request (line address), issues one AXI4 read burst of LINE_WORDS beats, and assembles the beats into a full cache line.
- Returns the line with a one-cycle rend_o pulse. The second stage latches its miss word and returns from READ to IDLE on that pulse.

Parameters:
- LINE_WORDS, 8: 32-bit words per cache line; the burst length is LINE_WORDS beats.
- AXI_ID, 4'd0: ARID value driven on every request.
- OFFSET_W, 5: byte-offset bits of a line (log2(LINE_WORDS*4)).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_i  in  1  miss request; level signal, held by the requester until rend_o
- addr_i  in  32  miss physical address; bits [OFFSET_W-1:0] are ignored unless ICACHE_CWF_EN
- rend_o  out  1  one-cycle pulse: line_o is complete
- line_o  out  32*LINE_WORDS  assembled line; word k sits at bits [32k+31:32k]
- busy_o  out  1  high in any state other than IDLE
- err_o  out  1  pulses together with rend_o if any RRESP!=OKAY or RLAST was misplaced
- arid_o  out  4  =AXI_ID
- araddr_o  out  32  burst start address
- arlen_o  out  8  =LINE_WORDS-1
- arsize_o  out  3  =3'b010
- arburst_o  out  2  INCR (2'b01); WRAP (2'b10) with ICACHE_CWF_EN
- arvalid_o  out  1  AR valid
- arready_i  in  1  AR ready
- rid_i  in  4  ignored
- rdata_i  in  32  read data beat
- rresp_i  in  2  read response
- rlast_i  in  1  last beat
- rvalid_i  in  1  R valid
- rready_o  out  1  R ready

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE.
  - arvalid_o=0, rready_o=0, rend_o=0, err_o=0, busy_o=0.
  - line_o=0, araddr_o=0, beat counter=0.
- All outputs are registered except the constants (arid_o, arlen_o, arsize_o, arburst_o) and busy_o, which decodes the state register.
- States: IDLE, AR, R, DONE.
- IDLE:
  - req_i=1: latch araddr_o={addr_i[31:OFFSET_W], 0}, clear the error flag, clear the beat counter, go to AR.
  - arvalid_o=1 from the next cycle.
- AR:
  - arvalid_o stays high and araddr_o stays stable until arready_i.
  - On the arvalid_o&arready_i cycle go to R; arvalid_o=0 and rready_o=1 from the next cycle.
- R:
  - rready_o=1 continuously.
  - Each rvalid_i cycle writes rdata_i into word[idx] and increments the 3-bit counter.
  - idx = counter (INCR mode).
  - rresp_i!=0 on any beat sets the sticky error flag.
  - On the beat where counter==LINE_WORDS-1: go to DONE, rready_o=0.
  - rlast_i on that beat is expected. Missing, or asserted on an earlier beat, sets the error flag. Completion is always counted by beats, never by rlast.
- DONE:
  - rend_o=1 and err_o=error flag for exactly one cycle, then IDLE.
  - req_i is not sampled in DONE. The requester drops req_i after rend_o, so no spurious second burst is issued.
- line_o holds its value from DONE until words are overwritten by the next burst. The consumer samples it only in the rend_o cycle.
- Latency (arready_i=1, rvalid_i every cycle):
  - req_i seen at cycle 0.
  - arvalid_o at cycle 1.
  - First beat accepted at cycle 2.
  - Eighth beat at cycle 9.
  - rend_o at cycle 10.
- Back-pressure: any number of idle cycles on rvalid_i or arready_i is tolerated with no state change.
- req_i changing while busy: ignored. The latched address governs the burst.
- Reset mid-burst: immediate return to IDLE.
  - Outstanding R beats arriving after reset are not accepted (rready_o=0).
  - System-level AXI reset is required to be simultaneous.

Optional Feature:
- Macro: ICACHE_CWF_EN (critical word first).
- Defined:
  - araddr_o={addr_i[31:2],2'b00}; arburst_o=WRAP.
  - Beat i is written to word[(addr_i[4:2]+i) mod LINE_WORDS]; the 3-bit index wraps naturally.
  - Completion, rend_o and line_o layout are unchanged.
- Undefined: line-aligned INCR burst as above; addr_i[4:0] unused.

Decomposition:
- defines_cache.v gains:
  - ICACHE_REFILL_IDLE/AR/R/DONE 2-bit state encodings.
  - AXI_BURST_INCR=2'b01, AXI_BURST_WRAP=2'b10, AXI_RESP_OKAY=2'b00.
  - ICACHE_LINE_BUS (255:0).
- One natural sub-module, icache_line_buf:
  - LINE_WORDS x 32 register array with write-enable, 3-bit index and 32-bit data.
  - Outputs the flattened line.
- The FSM, counter and AXI handshake stay in icache_axi_refill.

Test Plan:
- Basic refill:
  - Stimulus: req_i=1, addr_i=0x1FC0_0024, slave with zero wait, data 0xA0..0xA7 per beat.
  - Response: araddr_o=0x1FC0_0020, arlen_o=7, rend_o at cycle 10, line_o word0=0xA0 … word7=0xA7, err_o=0.
- Back-pressure:
  - Stimulus: arready_i delayed 3 cycles, rvalid_i toggling every other cycle.
  - Response: araddr_o stable while arvalid_o is high; the same line as the basic refill; rend_o exactly once.
- Error response:
  - Stimulus: beat 3 returns rresp_i=2'b10, and rlast_i is asserted on beat 6.
  - Response: the burst still completes after 8 beats; err_o=1 with rend_o.
- Reset mid-burst:
  - Stimulus: drop rst_n after beat 4, release, then issue a new req_i for 0x0000_1000.
  - Response: all outputs reset immediately; the new burst starts with araddr_o=0x0000_1000 and completes normally.
- Requester hold:
  - Stimulus: req_i held high through DONE for one extra cycle.
  - Response: exactly one AR handshake per miss; no second arvalid_o before req_i has been low in IDLE.
- Critical word first (ICACHE_CWF_EN defined):
  - Stimulus: addr_i=0x1FC0_0034, beats 0xB0..0xB7.
  - Response: araddr_o=0x1FC0_0034, arburst_o=2'b10, word5=0xB0, word7=0xB2, word0=0xB3, word4=0xB7.
